// File: rtl/fifo_synch_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module fifo_synch_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic [DATA_W-1:0]          buf_in,
  output logic [DATA_W-1:0]          buf_out,
  output logic                       rd_valid,
  output logic                       buf_empty,
  output logic                       buf_full,
  output logic                       buf_almost_empty,
  output logic                       buf_almost_full,
  output logic [$clog2(DEPTH):0]     fifo_counter,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;

  // Status flags decode straight from the occupancy register.
  assign buf_empty        = (count_q == '0);
  assign buf_full         = (count_q == DEPTH_C);
  assign buf_almost_empty = (count_q <= AE_C);
  assign buf_almost_full  = (count_q >= AF_C);
  assign fifo_counter     = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

  // Accept decisions; a flush cycle ignores both requests.
  always_comb begin
    rd_ok = rd_en & ~buf_empty & ~flush;
    wr_ok = wr_en & (~buf_full | rd_ok) & ~flush;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
      // A new error event wins over a coincident clear.
      if (wr_en && buf_full && !rd_ok) overflow_d = 1'b1;
      if (rd_en && buf_empty) underflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= buf_in;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] buf_out_q;
      logic              rd_valid_q;
      // Registered read: data loads on the accepting edge, valid for one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_out_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) buf_out_q <= mem_q[rd_ptr_q];
        end
      end
      assign buf_out  = buf_out_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented combinationally whenever something is stored.
      assign buf_out  = buf_empty ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = ~buf_empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_synch_param.sv
// Directed and scoreboard checks for fifo_synch_param, standard and FWFT modes.
module tb_fifo_synch_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Standard-read instance
  logic       w0 = 0, r0 = 0, f0 = 0, c0 = 0;
  logic [7:0] d0 = '0, o0;
  logic       v0, e0, fu0, ae0, af0, ov0, un0;
  logic [2:0] n0;
  // FWFT instance
  logic       w1 = 0, r1 = 0, f1 = 0, c1 = 0;
  logic [7:0] d1 = '0, o1;
  logic       v1, e1, fu1, ae1, af1, ov1, un1;
  logic [2:0] n1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  fifo_synch_param #(.DATA_W(8), .DEPTH(4), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(w0), .rd_en(r0), .flush(f0), .clr_err(c0),
    .buf_in(d0), .buf_out(o0), .rd_valid(v0), .buf_empty(e0), .buf_full(fu0),
    .buf_almost_empty(ae0), .buf_almost_full(af0), .fifo_counter(n0),
    .overflow(ov0), .underflow(un0));

  fifo_synch_param #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(w1), .rd_en(r1), .flush(f1), .clr_err(c1),
    .buf_in(d1), .buf_out(o1), .rd_valid(v1), .buf_empty(e1), .buf_full(fu1),
    .buf_almost_empty(ae1), .buf_almost_full(af1), .fifo_counter(n1),
    .overflow(ov1), .underflow(un1));

  // Drive u0 inputs for one cycle and return 1 time unit after the edge.
  task automatic step0(input logic w, input logic r, input logic f, input logic c,
                       input logic [7:0] d);
    @(negedge clk);
    w0 = w; r0 = r; f0 = f; c0 = c; d0 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    w1 = w; r1 = r; d1 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (n0 !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", n0); end
    tests++; if (o0 !== 8'h00) begin fails++; $display("FAIL reset_buf_out got %h want 00", o0); end
    tests++; if ({v0, e0, fu0, ae0, af0, ov0, un0} !== 7'b0101000) begin
      fails++; $display("FAIL reset_flags got %b want 0101000", {v0, e0, fu0, ae0, af0, ov0, un0}); end
    tests++; if ({v1, e1, o1} !== {2'b01, 8'h00}) begin
      fails++; $display("FAIL reset_fwft got v=%b e=%b o=%h want v=0 e=1 o=00", v1, e1, o1); end
    @(negedge clk); rst = 1'b0;
    step0(1, 0, 0, 0, 8'h3A);
    step0(1, 0, 0, 0, 8'h2A);
    tests++; if (n0 !== 3'd2) begin fails++; $display("FAIL midfill_count got %0d want 2", n0); end
    #2 rst = 1'b1;
    #1;
    tests++; if (n0 !== 3'd0 || e0 !== 1'b1) begin
      fails++; $display("FAIL async_reset got count=%0d empty=%b want 0 1", n0, e0); end
    @(negedge clk);
    w0 = 0; rst = 1'b0;
  endtask

  task automatic test_fill_overflow;
    logic [7:0] exp [4];
    exp[0] = 8'h3A; exp[1] = 8'h2A; exp[2] = 8'h48; exp[3] = 8'h11;
    step0(1, 0, 0, 0, exp[0]);
    tests++; if ({ae0, af0} !== 2'b10) begin fails++; $display("FAIL ae_af_at1 got %b want 10", {ae0, af0}); end
    step0(1, 0, 0, 0, exp[1]);
    tests++; if ({ae0, af0} !== 2'b11) begin fails++; $display("FAIL ae_af_at2 got %b want 11", {ae0, af0}); end
    step0(1, 0, 0, 0, exp[2]);
    tests++; if ({ae0, af0} !== 2'b01) begin fails++; $display("FAIL ae_af_at3 got %b want 01", {ae0, af0}); end
    step0(1, 0, 0, 0, exp[3]);
    tests++; if ({fu0, af0, n0} !== {2'b11, 3'd4}) begin
      fails++; $display("FAIL full got full=%b af=%b count=%0d want 1 1 4", fu0, af0, n0); end
    step0(1, 0, 0, 0, 8'h55);
    tests++; if ({ov0, n0} !== {1'b1, 3'd4}) begin
      fails++; $display("FAIL overflow got ovf=%b count=%0d want 1 4", ov0, n0); end
    for (int i = 0; i < 4; i++) begin
      step0(0, 1, 0, 0, 8'h00);
      tests++; if (o0 !== exp[i] || v0 !== 1'b1) begin
        fails++; $display("FAIL read%0d got %h v=%b want %h v=1", i, o0, v0, exp[i]); end
    end
    step0(0, 0, 0, 0, 8'h00);
    tests++; if ({v0, e0, o0} !== {2'b01, 8'h11}) begin
      fails++; $display("FAIL post_read got v=%b e=%b o=%h want 0 1 11", v0, e0, o0); end
  endtask

  task automatic test_underflow;
    step0(0, 1, 0, 0, 8'h00);
    tests++; if ({un0, n0, v0} !== {1'b1, 3'd0, 1'b0}) begin
      fails++; $display("FAIL underflow got un=%b count=%0d v=%b want 1 0 0", un0, n0, v0); end
    step0(0, 0, 0, 1, 8'h00);
    tests++; if ({un0, ov0} !== 2'b00) begin fails++; $display("FAIL clr_err got un=%b ov=%b want 0 0", un0, ov0); end
    step0(1, 1, 0, 0, 8'h77);
    tests++; if ({n0, un0, v0} !== {3'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL empty_wr_rd got count=%0d un=%b v=%b want 1 1 0", n0, un0, v0); end
    step0(0, 1, 0, 1, 8'h00);
    tests++; if ({o0, v0, un0, e0} !== {8'h77, 3'b101}) begin
      fails++; $display("FAIL read77 got o=%h v=%b un=%b e=%b want 77 1 0 1", o0, v0, un0, e0); end
  endtask

  task automatic test_full_simul;
    for (int i = 1; i <= 4; i++) step0(1, 0, 0, 0, 8'(i));
    step0(1, 1, 0, 0, 8'hA5);
    tests++; if ({n0, ov0, o0, v0} !== {3'd4, 1'b0, 8'h01, 1'b1}) begin
      fails++; $display("FAIL full_wr_rd got count=%0d ov=%b o=%h v=%b want 4 0 01 1", n0, ov0, o0, v0); end
    for (int i = 2; i <= 4; i++) begin
      step0(0, 1, 0, 0, 8'h00);
      tests++; if (o0 !== 8'(i)) begin fails++; $display("FAIL wrap_read got %h want %h", o0, 8'(i)); end
    end
    step0(0, 1, 0, 0, 8'h00);
    tests++; if ({o0, e0} !== {8'hA5, 1'b1}) begin
      fails++; $display("FAIL wrap_last got o=%h e=%b want a5 1", o0, e0); end
  endtask

  task automatic test_flush;
    step0(0, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 3; i++) step0(1, 0, 0, 0, 8'(8'h10 * i));
    tests++; if (n0 !== 3'd3) begin fails++; $display("FAIL preflush_count got %0d want 3", n0); end
    step0(1, 0, 1, 0, 8'hEE);
    tests++; if ({n0, e0, un0, ov0, v0, o0} !== {3'd0, 4'b1100, 8'hA5}) begin
      fails++; $display("FAIL flush got count=%0d e=%b un=%b ov=%b v=%b o=%h want 0 1 1 0 0 a5",
                        n0, e0, un0, ov0, v0, o0); end
    step0(1, 0, 0, 0, 8'h99);
    step0(0, 1, 0, 0, 8'h00);
    tests++; if ({o0, e0} !== {8'h99, 1'b1}) begin
      fails++; $display("FAIL postflush_read got o=%h e=%b want 99 1", o0, e0); end
    step0(0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_fwft;
    step1(1, 0, 8'hC3);
    tests++; if ({o1, v1} !== {8'hC3, 1'b1}) begin
      fails++; $display("FAIL fwft_first got o=%h v=%b want c3 1", o1, v1); end
    step1(1, 0, 8'hD4);
    tests++; if (o1 !== 8'hC3) begin fails++; $display("FAIL fwft_hold got %h want c3", o1); end
    step1(0, 1, 8'h00);
    tests++; if ({o1, v1} !== {8'hD4, 1'b1}) begin
      fails++; $display("FAIL fwft_pop got o=%h v=%b want d4 1", o1, v1); end
    step1(0, 1, 8'h00);
    tests++; if ({v1, e1} !== 2'b01) begin fails++; $display("FAIL fwft_empty got v=%b e=%b want 0 1", v1, e1); end
    step1(0, 0, 8'h00);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] exp_out = 8'h99;
    logic exp_v = 0, exp_ov = 0, exp_un = 0, rok, wok;
    logic w, r, f, c;
    logic [7:0] d;
    int unsigned sz;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 63) == 0); c = ($urandom_range(0, 31) == 0);
      d = 8'($urandom);
      sz = q.size();
      exp_ov = exp_ov & ~c;
      exp_un = exp_un & ~c;
      if (f) begin
        q.delete(); exp_v = 0;
      end else begin
        rok = r && sz > 0;
        wok = w && (sz < 4 || rok);
        if (w && sz == 4 && !rok) exp_ov = 1;
        if (r && sz == 0) exp_un = 1;
        exp_v = rok;
        if (rok) exp_out = q.pop_front();
        if (wok) q.push_back(d);
      end
      step0(w, r, f, c, d);
      sz = q.size();
      tests++; if (n0 !== 3'(sz)) begin fails++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, n0, sz); end
      tests++; if ({o0, v0} !== {exp_out, exp_v}) begin
        fails++; $display("FAIL rnd_data cyc %0d got %h v=%b want %h v=%b", cyc, o0, v0, exp_out, exp_v); end
      tests++; if ({e0, fu0, ae0, af0} !== {sz == 0, sz == 4, sz <= 2, sz >= 2}) begin
        fails++; $display("FAIL rnd_flags cyc %0d got %b want %b", cyc, {e0, fu0, ae0, af0},
                          {sz == 0, sz == 4, sz <= 2, sz >= 2}); end
      tests++; if ({ov0, un0} !== {exp_ov, exp_un}) begin
        fails++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, {ov0, un0}, {exp_ov, exp_un}); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_full_simul();
    test_flush();
    test_fwft();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
